button_event_decoder: RTL
=========================

BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, clock frequency in Hz; SHALL be a multiple of 1000.
REQ-002 Parameter LONG_MS, default 1000, press duration in ms at or above which a press is "long".
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 btn_tgl  in  1  toggle-encoded debounced button: each level change is one press or release, starting released at level 0.
REQ-006 press_pulse  out  1  one-cycle strobe on each decoded press.
REQ-007 release_pulse  out  1  one-cycle strobe on each decoded release.
REQ-008 long_hold  out  1  one-cycle strobe when a held press reaches LONG_MS.
REQ-009 held  out  1  high while the button is decoded as pressed.
REQ-010 evt_valid  out  1  event record available at buffer head.
REQ-011 evt_ready  in  1  consumer accepts the head record.
REQ-012 evt_long  out  1  head record: press duration >= LONG_MS.
REQ-013 evt_ms  out  16  head record: press duration in ms, saturating at 16'hFFFF.
REQ-014 evt_overflow  out  1  sticky: a record was dropped because the buffer was full.

Function
REQ-015 btn_tgl SHALL pass through a 2-flop synchronizer, then a history flop; change = synchronized value != history.
REQ-016 A btn_tgl transition SHALL produce its strobe exactly 3 rising edges after the first edge that samples the new level.
REQ-017 State machine SHALL have two states: RELEASED, PRESSED; change in RELEASED -> PRESSED with press_pulse; change in PRESSED -> RELEASED with release_pulse.
REQ-018 held SHALL be 1 exactly when the state is PRESSED.
REQ-019 A ms prescaler SHALL count 0..CLK_HZ/1000-1, restart at 0 on entry to PRESSED, and emit a one-cycle ms tick on wrap.
REQ-020 The 16-bit ms counter SHALL clear on entry to PRESSED, increment on each tick while PRESSED, and saturate at 16'hFFFF.
REQ-021 long_hold SHALL fire once per press, in the cycle the ms counter becomes LONG_MS; never if released first.
REQ-022 On release, a record {long = ms >= LONG_MS, ms} SHALL be pushed to a 2-entry FIFO in the cycle release_pulse is high.
REQ-023 A record SHALL pop when evt_valid && evt_ready; evt_long/evt_ms SHALL stay stable while evt_valid && !evt_ready.
REQ-024 evt_valid SHALL rise in the cycle after the push; push into empty FIFO SHALL not bypass this latency.
REQ-025 Push and pop in the same cycle SHALL both take effect, including when the FIFO is full (no drop).
REQ-026 Push to a full FIFO without a same-cycle pop SHALL discard the new record and set evt_overflow until reset.
REQ-027 Presses shorter than 1 ms SHALL produce a record with evt_ms = 0 and evt_long = 0.

Reset
REQ-028 rst SHALL force: synchronizer and history flops 0, state RELEASED, prescaler and ms counter 0, FIFO empty, all outputs 0.
REQ-029 rst asserted mid-press SHALL discard the press with no record; a press in progress is not resumed after reset.
REQ-030 After rst deasserts, btn_tgl level 1 SHALL be decoded as one press after 3 edges.

Structure
REQ-031 Package button_pkg SHALL hold the state enum, MS_W = 16, FIFO_DEPTH = 2, and the record struct {long, ms}.
REQ-032 Prescaler SHALL be sub-module ms_tick_gen (params CLK_HZ; ports clk, rst, restart, tick); FIFO stays inline.

Verification (CLK_HZ = 10_000 -> 10 cycles/ms, LONG_MS = 5)
REQ-033 btn_tgl 0->1 at cycle 100 -> press_pulse at cycle 103 only, held=1 from 103.
REQ-034 Hold 25 cycles then toggle -> release_pulse once; record evt_ms=2, evt_long=0; evt_valid next cycle.
REQ-035 Hold 80 cycles -> long_hold once at ms=5; record evt_ms=8, evt_long=1.
REQ-036 evt_ready=0, three press/release pairs -> two records held in order, evt_overflow=1, third lost; then evt_ready=1 -> two pops, evt_valid=0.
REQ-037 FIFO full, evt_ready=1 in release cycle -> no drop, evt_overflow stays 0, order preserved.
REQ-038 rst pulse while held at ms=3 -> all outputs 0, no record; btn_tgl held at 1 -> press_pulse 3 edges after rst release.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and sizing for the button event decoder: FSM states,
// event record layout and a saturating millisecond increment.
package button_pkg;

  localparam int MS_W       = 16;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } btn_state_e;

  typedef struct packed {
    logic            long;
    logic [MS_W-1:0] ms;
  } evt_rec_t;

  function automatic logic [MS_W-1:0] sat_inc(input logic [MS_W-1:0] v);
    return (v == '1) ? v : v + MS_W'(1);
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..CLK_HZ/1000-1 and strobes tick on the
// last count; restart forces the count back to 0.
module ms_tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int DIV = CLK_HZ / 1000;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/button_event_decoder.sv
// Decodes a toggle-encoded button into press/release/long-hold strobes and
// queues {long, ms} duration records in a 2-entry FIFO.
module button_event_decoder
  import button_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int LONG_MS = 1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btn_tgl,
  output logic            press_pulse,
  output logic            release_pulse,
  output logic            long_hold,
  output logic            held,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic            evt_long,
  output logic [MS_W-1:0] evt_ms,
  output logic            evt_overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  // Input synchronizer, history flop and registered change flag.
  logic sync1, sync2, hist, chg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
      chg_q <= 1'b0;
    end else begin
      sync1 <= btn_tgl;
      sync2 <= sync1;
      hist  <= sync2;
      chg_q <= sync2 ^ hist;
    end
  end

  btn_state_e state, state_nxt;
  logic       press_d, release_d;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state)
      RELEASED: if (chg_q) begin
        state_nxt = PRESSED;
        press_d   = 1'b1;
      end
      PRESSED: if (chg_q) begin
        state_nxt = RELEASED;
        release_d = 1'b1;
      end
      default: state_nxt = RELEASED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RELEASED;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      press_pulse   <= press_d;
      release_pulse <= release_d;
    end
  end

  assign held = (state == PRESSED);

  logic            ms_tick;
  logic [MS_W-1:0] ms_cnt;

  ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_ms_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(press_d),
    .tick   (ms_tick)
  );

  // long_hold is registered alongside ms_cnt so it strobes in the cycle the
  // count first equals LONG_MS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ms_cnt    <= '0;
      long_hold <= 1'b0;
    end else begin
      long_hold <= held && ms_tick && (ms_cnt != '1) && ((int'(ms_cnt) + 1) == LONG_MS);
      if (press_d) begin
        ms_cnt <= '0;
      end else if (held && ms_tick) begin
        ms_cnt <= sat_inc(ms_cnt);
      end
    end
  end

  // Record FIFO: pushed while release_pulse is high, popped on handshake.
  evt_rec_t          rec_in, head;
  evt_rec_t          mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push, pop, full, wr_en;

  assign rec_in.long = (int'(ms_cnt) >= LONG_MS);
  assign rec_in.ms   = ms_cnt;
  assign push        = release_pulse;
  assign full        = (count == FULL_CNT);
  assign pop         = evt_valid && evt_ready;
  assign wr_en       = push && (!full || pop);

  // NOTE: the storage array has no reset; count alone defines emptiness and
  // the outputs are masked while nothing is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= rec_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      evt_overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) evt_overflow <= 1'b1;
    end
  end

  assign evt_valid = (count != '0);
  assign head      = mem[rd_ptr];
  assign evt_long  = evt_valid && head.long;
  assign evt_ms    = evt_valid ? head.ms : '0;

endmodule
